led_display_arbiter: RTL and testbench
======================================

Name: led_display_arbiter

Overview:
Shares the board's 6 active-low LEDs between NUM_REQ requesters. Each requester asks to show a 6-bit pattern for a fixed hold time, and requests are granted round-robin. With no request pending, the block runs the default rotating single-LED chaser at a programmable step rate. It sits between the status/debug sources in the top level and the LED pins.

Parameters:
- NUM_REQ, 3: number of requesters.
- LED_W, 6: LED count.
- TICK_DIV, 27000: sys_clk cycles per tick (1 ms at 27 MHz).
- HOLD_TICKS, 500: ticks a granted pattern is displayed (0.5 s).
- GAP_TICKS, 1: ticks all LEDs stay off between grants.
- STEP_TICKS, 500: ticks per chaser step in idle.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset.
- req  in  NUM_REQ  level request, one bit per requester.
- req_pattern  in  NUM_REQ*LED_W  pattern for requester i in bits [i*LED_W +: LED_W]; 1 = LED on.
- gnt  out  NUM_REQ  one-hot, high for the whole hold.
- done  out  NUM_REQ  one-cycle pulse when a hold completes normally.
- busy  out  1  high when not in IDLE.
- led  out  LED_W  LED pins, active-low (0 = lit).

Behaviour:
- Reset: sys_rst_n asynchronous, active-low; clock sys_clk. All registers and outputs reset asynchronously. Reset values:
  - led = 6'b111110; chaser register = 6'b111110
  - gnt = 0, done = 0, busy = 0
  - state = IDLE; prescaler = 0
  - rr pointer last = NUM_REQ-1, so req0 has first priority.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle pulse when count == TICK_DIV-1.
  - A synchronous clear forces count to 0 and has priority over counting.
- States: IDLE, HOLD, GAP.
- IDLE:
  - led = chaser.
  - A step counter counts ticks. On reaching STEP_TICKS ticks, the chaser rotates left ({c[4:0],c[5]}) and the step counter resets.
  - If any req is high in cycle N: pick the first requester after last, in circular order. Latch its pattern. Clear the prescaler. Load hold_cnt = HOLD_TICKS-1. Go to HOLD.
  - At N+1: gnt = onehot(i), led = ~pattern, busy = 1, last = i.
- HOLD:
  - The chaser and step counter freeze; chaser position is preserved.
  - On tick, hold_cnt decrements.
  - Tick with hold_cnt == 0: next cycle gnt = 0, done[i] = 1 for one cycle, led = 6'b111111, enter GAP with gap_cnt = GAP_TICKS-1 and prescaler cleared.
  - gnt is high for exactly HOLD_TICKS*TICK_DIV cycles.
  - If req[i] drops during HOLD: next cycle gnt = 0, no done, led = all off, enter GAP (abort).
  - Changes to req_pattern during HOLD are ignored because the pattern is latched.
  - If the abort condition and the final tick coincide, treat it as an abort: no done.
- GAP:
  - led = 6'b111111; gnt = 0.
  - On tick with gap_cnt == 0: if any req is high, arbitrate exactly as in IDLE (grant visible next cycle). Otherwise go to IDLE; led = chaser and busy = 0 next cycle.
  - Requests arriving during GAP wait; no grant is issued mid-gap.
- Counter widths: $clog2 of max(value, 2). Counters never underflow; the decrement is gated by a nonzero check.
- Reset mid-operation returns immediately to the reset values. No done is emitted.
- req_pattern bits of non-granted requesters are don't-care.

Decomposition:
- Package led_ctrl_pkg holds:
  - state enum {IDLE, HOLD, GAP}
  - LED_W = 6
  - LED_OFF = 6'b111111
  - CHASER_INIT = 6'b111110
- Sub-module tick_prescaler (params TICK_DIV; ports sys_clk, sys_rst_n, clr, tick).
- Round-robin pick stays inline as a function in led_display_arbiter.

Test Plan:
All scenarios use TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=1, STEP_TICKS=2, NUM_REQ=3.
1. Reset, then idle with no req -> led = 111110, gnt = 0, busy = 0. After 8 cycles led = 111101; after 48 cycles it wraps back to 111110.
2. req = 3'b010 with pattern1 = 6'b101010 at cycle N:
   - N+1: gnt = 010, led = 010101, busy = 1, held 12 cycles.
   - N+13: done = 010 for one cycle, led = 111111.
   - N+17: led = chaser at its frozen position, busy = 0.
3. req = 3'b111 held continuously -> grant order 001, 010, 100, 001. Each gnt lasts 12 cycles with a 4-cycle all-off gap; one done pulse per grant.
4. req0 granted, req0 dropped 5 cycles into HOLD -> gnt = 0 on the next cycle, done stays 0, led = 111111 for one tick, then IDLE.
5. sys_rst_n asserted mid-HOLD -> same cycle: gnt = 0, done = 0, led = 111110. After release, req2 alone is granted with no stale priority effects (last = 2, so req2 wins).
6. Pattern changed during HOLD, plus a new req during GAP -> led keeps the latched pattern. The new request is granted only at the GAP tick; gnt rises 4 cycles after GAP entry + 1.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// led_ctrl_pkg : shared types and constants for the LED display arbiter. Rev 1.0
// ============================================================================
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int              LED_W       = 6;
    localparam logic [LED_W-1:0] LED_OFF     = 6'b111111;
    localparam logic [LED_W-1:0] CHASER_INIT = 6'b111110;

    // Counters are never narrower than one bit, even for tiny terminal values.
    function automatic int cnt_w(input int value);
        return $clog2((value < 2) ? 2 : value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_display_arbiter_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : free-running divider, one-cycle tick every TICK_DIV clocks. Rev 1.0
// ============================================================================
module tick_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 27000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W   = cnt_w(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over counting so a new phase always starts a full period.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clr) begin
            count_d = '0;
        end else if (count_q == CNT_MAX) begin
            count_d = '0;
        end
    end

    assign tick = (count_q == CNT_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_display_arbiter.sv
`default_nettype none
// ============================================================================
// led_display_arbiter : round-robin sharing of the active-low LEDs, chaser when idle. Rev 1.0
// ============================================================================
module led_display_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int LED_W      = led_ctrl_pkg::LED_W,
    parameter int TICK_DIV   = 27000,
    parameter int HOLD_TICKS = 500,
    parameter int GAP_TICKS  = 1,
    parameter int STEP_TICKS = 500
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] req_pattern,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [LED_W-1:0]         led
);

    localparam int IDX_W  = cnt_w(NUM_REQ);
    localparam int HOLD_W = cnt_w(HOLD_TICKS);
    localparam int GAP_W  = cnt_w(GAP_TICKS);
    localparam int STEP_W = cnt_w(STEP_TICKS);

    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [LED_W-1:0]  LED_DARK  = LED_W'(LED_OFF);
    localparam logic [LED_W-1:0]  CHASE_RST = LED_W'(CHASER_INIT);

    // First requester strictly after 'last' in circular order.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && r[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [LED_W-1:0]    chaser_q, chaser_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;

    logic                tick;
    logic                presc_clr;
    logic                any_req;
    logic [IDX_W-1:0]    pick;
    logic [LED_W-1:0]    pick_pattern;
    logic                grant_now;
    logic                enter_gap;
    logic                hold_done;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (presc_clr),
        .tick      (tick)
    );

    assign any_req      = |req;
    assign pick         = rr_pick(req, last_q);
    assign pick_pattern = req_pattern[int'(pick)*LED_W +: LED_W];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        busy_d     = busy_q;
        led_d      = led_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        chaser_d   = chaser_q;
        step_cnt_d = step_cnt_q;
        presc_clr  = 1'b0;
        grant_now  = 1'b0;
        enter_gap  = 1'b0;
        hold_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_now = 1'b1;
                end else begin
                    if (tick) begin
                        if (step_cnt_q == STEP_LAST) begin
                            chaser_d   = {chaser_q[LED_W-2:0], chaser_q[LED_W-1]};
                            step_cnt_d = '0;
                        end else begin
                            step_cnt_d = step_cnt_q + STEP_W'(1);
                        end
                    end
                    led_d = chaser_d;
                end
            end

            HOLD: begin
                // A dropped request aborts even on the final tick: no done.
                if (!req[last_q]) begin
                    enter_gap = 1'b1;
                end else if (tick) begin
                    if (hold_cnt_q == '0) begin
                        enter_gap = 1'b1;
                        hold_done = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
            end

            GAP: begin
                if (tick) begin
                    if (gap_cnt_q == '0) begin
                        if (any_req) begin
                            grant_now = 1'b1;
                        end else begin
                            state_d = IDLE;
                            led_d   = chaser_q;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                led_d   = chaser_q;
            end
        endcase

        if (enter_gap) begin
            state_d   = GAP;
            gnt_d     = '0;
            done_d    = hold_done ? gnt_q : '0;
            led_d     = LED_DARK;
            gap_cnt_d = GAP_LOAD;
            presc_clr = 1'b1;
        end

        // The pattern is captured into led_q here and left untouched for the hold.
        if (grant_now) begin
            state_d    = HOLD;
            gnt_d      = onehot(pick);
            led_d      = ~pick_pattern;
            busy_d     = 1'b1;
            last_d     = pick;
            hold_cnt_d = HOLD_LOAD;
            presc_clr  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            led_q      <= CHASE_RST;
            last_q     <= LAST_RST;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            chaser_q   <= CHASE_RST;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            led_q      <= led_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            chaser_q   <= chaser_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign led  = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_display_arbiter.sv
`default_nettype none
// ============================================================================
// tb_led_display_arbiter : random requests checked against a cycle-timeline model. Rev 1.0
// ============================================================================
module tb_led_display_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int LED_W      = 6;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 3;
    localparam int GAP_TICKS  = 1;
    localparam int STEP_TICKS = 2;
    localparam int PW         = NUM_REQ * LED_W;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_GAP  = 2;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [PW-1:0]        req_pattern;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [LED_W-1:0]     led;

    always #5 sys_clk = ~sys_clk;

    led_display_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LED_W      (LED_W),
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .STEP_TICKS (STEP_TICKS)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req         (req),
        .req_pattern (req_pattern),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .led         (led)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: timeline in cycles since the last grant/gap start,
    // chaser position derived from the total number of idle ticks.
    int                 m_mode;
    int                 m_ph;
    int                 m_idle_ticks;
    int                 m_last;
    int                 m_elapsed;
    logic [NUM_REQ-1:0] e_gnt;
    logic [NUM_REQ-1:0] e_done;
    logic               e_busy;
    logic [LED_W-1:0]   e_led;

    function automatic logic [LED_W-1:0] chaser_at(input int ticks);
        logic [LED_W-1:0] c;
        c = 6'b111110;
        for (int s = 0; s < (ticks / STEP_TICKS) % LED_W; s++) begin
            c = {c[LED_W-2:0], c[LED_W-1]};
        end
        return c;
    endfunction

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_ph         = 0;
        m_idle_ticks = 0;
        m_last       = NUM_REQ - 1;
        m_elapsed    = 0;
        e_gnt        = '0;
        e_done       = '0;
        e_busy       = 1'b0;
        e_led        = 6'b111110;
    endtask

    task automatic model_grant();
        int p;
        p = m_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (req[(m_last + k) % NUM_REQ]) begin
                p = (m_last + k) % NUM_REQ;
                break;
            end
        end
        m_last    = p;
        e_gnt     = '0;
        e_gnt[p]  = 1'b1;
        e_led     = ~req_pattern[p*LED_W +: LED_W];
        e_busy    = 1'b1;
        m_mode    = M_HOLD;
        m_elapsed = 1;
        m_ph      = 0;
    endtask

    task automatic model_gap(input bit completed);
        e_done    = completed ? e_gnt : '0;
        e_gnt     = '0;
        e_led     = 6'b111111;
        m_mode    = M_GAP;
        m_elapsed = 1;
        m_ph      = 0;
    endtask

    task automatic model_step();
        bit tick;
        tick   = (m_ph % TICK_DIV) == TICK_DIV - 1;
        e_done = '0;
        if (m_mode == M_IDLE) begin
            if (req != '0) begin
                model_grant();
            end else begin
                if (tick) m_idle_ticks++;
                e_led = chaser_at(m_idle_ticks);
                m_ph++;
            end
        end else if (m_mode == M_HOLD) begin
            if (!req[m_last]) begin
                model_gap(1'b0);
            end else if (m_elapsed == HOLD_TICKS * TICK_DIV) begin
                model_gap(1'b1);
            end else begin
                m_elapsed++;
                m_ph++;
            end
        end else begin
            if (m_elapsed == GAP_TICKS * TICK_DIV) begin
                if (req != '0) begin
                    model_grant();
                end else begin
                    m_mode = M_IDLE;
                    e_led  = chaser_at(m_idle_ticks);
                    e_busy = 1'b0;
                    m_ph++;
                end
            end else begin
                m_elapsed++;
                m_ph++;
            end
        end
    endtask

    task automatic compare_all(input string phase);
        check_eq({phase, ".gnt"},  32'(gnt),  32'(e_gnt));
        check_eq({phase, ".done"}, 32'(done), 32'(e_done));
        check_eq({phase, ".busy"}, 32'(busy), 32'(e_busy));
        check_eq({phase, ".led"},  32'(led),  32'(e_led));
    endtask

    // Called at a negedge: perturb inputs, advance one clock, compare.
    task automatic run_cycle(input int toggle_per_mil, input string phase);
        for (int b = 0; b < NUM_REQ; b++) begin
            if ($urandom_range(999) < toggle_per_mil) req[b] = ~req[b];
        end
        req_pattern = PW'($urandom);
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        compare_all(phase);
    endtask

    task automatic mid_reset();
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        req = 3'b100;
        @(posedge sys_clk);
        @(negedge sys_clk);
        compare_all("rst_held");
        sys_rst_n = 1'b1;
        run_cycle(0, "post_rst_req2");
    endtask

    initial begin
        bit rst_pending;
        rst_pending = 1'b0;
        sys_rst_n   = 1'b0;
        req         = '0;
        req_pattern = '0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        compare_all("reset");
        sys_rst_n = 1'b1;

        // Idle chaser over a full wrap.
        for (int i = 0; i < 60; i++) run_cycle(0, "idle");

        // Busy random traffic with frequent aborts, and resets landing mid-hold.
        for (int i = 0; i < 1200; i++) begin
            if (i % 250 == 200) rst_pending = 1'b1;
            if (rst_pending && m_mode == M_HOLD) begin
                mid_reset();
                rst_pending = 1'b0;
            end else begin
                run_cycle(30, "rand_fast");
            end
        end

        // Slowly changing requests: mostly complete holds.
        for (int i = 0; i < 600; i++) run_cycle(6, "rand_slow");

        // All requesters continuously: pure round-robin rotation.
        req = '1;
        for (int i = 0; i < 100; i++) run_cycle(0, "rr_all");

        // Release everything and let the chaser resume.
        req = '0;
        for (int i = 0; i < 40; i++) run_cycle(0, "drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
